seq_div: RTL and testbench

Multi-cycle restoring divider: the inverse of the team's 16x16 shift-add multiplier. Takes a 32-bit dividend (a multiplier product width) and a 16-bit divisor and returns a 32-bit quotient and 16-bit remainder, one quotient bit per clock. Sits beside the multiplier in the ALU datapath. A start/done handshake lets the ALU controller launch an operation and wait for the result.

---
 rtl/seq_div.sv | 93 +++++++++
 tb/tb_seq_div.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/seq_div.sv
// Multi-cycle unsigned restoring divider: 2N-bit dividend / N-bit divisor,
// one quotient bit per clock, start/done handshake for the ALU controller.
module seq_div #(
    parameter int N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           start,
    input  logic [2*N-1:0] a,
    input  logic [N-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*N-1:0] q,
    output logic [N-1:0]   r,
    output logic           dz
);
    localparam int CW = $clog2(2*N+1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [2*N-1:0] dq;
    logic [N:0]     rem;
    logic [N-1:0]   dvs;
    logic [CW-1:0]  cnt;
    logic [N:0]     sh;
    logic [N:0]     t;

    // rem < divisor between steps, so its top bit is always zero before the shift
    assign sh = {rem[N-1:0], dq[2*N-1]};
    assign t  = sh - {1'b0, dvs};

    always_comb begin
        state_nxt = state;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (cnt == '0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // A zero divisor still passes through RUN with cnt=0, giving the one-cycle
    // gap before DONE; its result is written at acceptance and kept by the dz gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq  <= '0;
            rem <= '0;
            dvs <= '0;
            cnt <= '0;
            q   <= '0;
            r   <= '0;
            dz  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (b != '0) begin
                            dq  <= a;
                            dvs <= b;
                            rem <= '0;
                            cnt <= CW'(2*N);
                            dz  <= 1'b0;
                        end else begin
                            q   <= '1;
                            r   <= a[N-1:0];
                            dz  <= 1'b1;
                            cnt <= '0;
                        end
                    end
                end
                RUN: begin
                    if (cnt != '0) begin
                        rem <= t[N] ? sh : t;
                        dq  <= {dq[2*N-2:0], ~t[N]};
                        cnt <= cnt - CW'(1);
                    end else if (!dz) begin
                        q <= dq;
                        r <= rem[N-1:0];
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_div.sv
// Directed bench for seq_div: vector table plus hand-written sequences for
// ignored start, held start and mid-operation reset.
module tb_seq_div;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] a;
    logic [15:0] b;
    logic        busy, done, dz;
    logic [31:0] q;
    logic [15:0] r;

    int nvec = 0;
    int nerr = 0;

    seq_div #(.N(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .q(q), .r(r), .dz(dz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic [31:0] q;
        logic [15:0] r;
        logic        dz;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Launch one op; report the edge index (E0 = accept) where done first
    // shows and where busy falls. -1 means the bound expired.
    task automatic run_op(input logic [31:0] ta, input logic [15:0] tb_,
                          output int done_edge, output int fall_edge);
        @(negedge clk);
        a = ta; b = tb_; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        done_edge = -1;
        fall_edge = -1;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (done && done_edge < 0) done_edge = k;
            if (!busy) begin
                fall_edge = k;
                break;
            end
        end
    endtask

    vec_t vecs[9];
    int   de, fe;

    initial begin
        vecs[0] = '{32'd2500,       16'd50,     32'd50,         16'd0,      1'b0};
        vecs[1] = '{32'hFFFFFFFF,   16'hFFFF,   32'h00010001,   16'd0,      1'b0};
        vecs[2] = '{32'd1000,       16'd7,      32'd142,        16'd6,      1'b0};
        vecs[3] = '{32'd5,          16'd9,      32'd0,          16'd5,      1'b0};
        vecs[4] = '{32'h12345678,   16'd1,      32'h12345678,   16'd0,      1'b0};
        vecs[5] = '{32'd1234,       16'd0,      32'hFFFFFFFF,   16'h04D2,   1'b1};
        vecs[6] = '{32'd100,        16'd10,     32'd10,         16'd0,      1'b0};
        vecs[7] = '{32'hFFFFFFFF,   16'd2,      32'h7FFFFFFF,   16'd1,      1'b0};
        vecs[8] = '{32'h80000000,   16'h8000,   32'h00010000,   16'd0,      1'b0};

        rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset q", q, 0);
        chk("reset r", r, 0);
        chk("reset dz", dz, 0);
        @(negedge clk); rst_n = 1'b1;

        for (int i = 0; i < 9; i++) begin
            run_op(vecs[i].a, vecs[i].b, de, fe);
            chk($sformatf("v%0d done edge", i), de, vecs[i].dz ? 1 : 33);
            chk($sformatf("v%0d busy fall", i), fe, vecs[i].dz ? 2 : 34);
            chk($sformatf("v%0d q", i), q, vecs[i].q);
            chk($sformatf("v%0d r", i), r, vecs[i].r);
            chk($sformatf("v%0d dz", i), dz, vecs[i].dz);
        end

        // start pulse mid-run with different operands must be ignored
        begin
            int d1 = -1;
            @(negedge clk);
            a = 32'd2500; b = 16'd50; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            for (int k = 1; k <= 60; k++) begin
                @(posedge clk); #1;
                if (k == 9)  begin a = 32'd7; b = 16'd2; start = 1'b1; end
                if (k == 10) start = 1'b0;
                if (done && d1 < 0) d1 = k;
                if (!busy) break;
            end
            chk("ignored start done edge", d1, 33);
            chk("ignored start q", q, 50);
            chk("ignored start r", r, 0);
        end

        // start held high: next acceptance on first edge seen in IDLE
        begin
            int d1 = -1, f1 = -1, d2 = -1;
            logic [31:0] q2 = '0;
            logic [15:0] r2 = '0;
            @(negedge clk);
            a = 32'd2500; b = 16'd50; start = 1'b1;
            @(posedge clk); #1;
            a = 32'd1000; b = 16'd7;
            for (int k = 1; k <= 80; k++) begin
                @(posedge clk); #1;
                if (done && d1 < 0) d1 = k;
                else if (done && d2 < 0 && f1 > 0) begin d2 = k; q2 = q; r2 = r; end
                if (!busy && f1 < 0) f1 = k;
                if (d2 > 0) break;
            end
            start = 1'b0;
            chk("held first done edge", d1, 33);
            chk("held busy fall", f1, 34);
            chk("held second done edge", d2, 68);
            chk("held second q", q2, 142);
            chk("held second r", r2, 6);
            for (int k = 0; k < 10 && busy; k++) @(posedge clk);
            #1;
            chk("held idle after", busy, 0);
        end

        // asynchronous reset mid-run discards the operation
        begin
            int dcnt = 0;
            @(negedge clk);
            a = 32'd1000; b = 16'd7; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            repeat (15) @(posedge clk);
            #1;
            chk("pre-reset busy", busy, 1);
            rst_n = 1'b0;
            #1;
            chk("midrun rst busy", busy, 0);
            chk("midrun rst done", done, 0);
            chk("midrun rst q", q, 0);
            chk("midrun rst r", r, 0);
            @(negedge clk); @(negedge clk);
            rst_n = 1'b1;
            for (int k = 0; k < 40; k++) begin
                @(posedge clk); #1;
                if (done) dcnt++;
            end
            chk("no done after reset", dcnt, 0);
            run_op(32'd1000, 16'd7, de, fe);
            chk("post-reset done edge", de, 33);
            chk("post-reset q", q, 142);
            chk("post-reset r", r, 6);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
